// File: rtl/radix4_div_pkg.sv
// Shared types and constants for the radix-4 restoring divider.
package radix4_pkg;

  localparam int unsigned RADIX_SHIFT = 2;
  localparam int unsigned DEF_WIDTH   = 8;
  localparam int unsigned ITER        = DEF_WIDTH / RADIX_SHIFT;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Number of radix-4 iterations for a given operand width.
  function automatic int unsigned iter_count(input int unsigned width);
    return width / RADIX_SHIFT;
  endfunction

endpackage

// File: rtl/radix4_div_shl_2.sv
// Combinational left shift by two: mirror of the datapath's shr_2 stage.
module shl_2 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH+1:0] in_i,
  input  logic [1:0]       inadd_i,
  output logic [WIDTH+1:0] out_c,
  output logic [1:0]       res_c
);

  assign out_c = {in_i[WIDTH-1:0], inadd_i};
  assign res_c = in_i[WIDTH+1:WIDTH];

endmodule

// File: rtl/radix4_div.sv
// Sequential unsigned radix-4 restoring divider, two quotient bits per clock,
// with a start/busy/done handshake.
module radix4_div
  import radix4_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned ITER_N = iter_count(WIDTH);
  localparam int unsigned CNT_W  = (ITER_N > 1) ? $clog2(ITER_N) : 1;
  localparam int unsigned PW     = WIDTH + 2;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]      p_q, p_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [WIDTH-1:0]   d_q, d_d;
  logic               dbz_pend_q, dbz_pend_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic               dbz_q, dbz_d;

  logic [PW-1:0]      p_sh_c;
  logic [1:0]         unused_res_c;
  logic [PW-1:0]      d1_c, d2_c, d3_c;
  logic [PW-1:0]      p_rem_c;
  logic [1:0]         digit_c;
  logic [WIDTH-1:0]   q_next_c;

  shl_2 #(.WIDTH(WIDTH)) u_shl_2 (
    .in_i    (p_q),
    .inadd_i (q_q[WIDTH-1:WIDTH-2]),
    .out_c   (p_sh_c),
    .res_c   (unused_res_c)
  );

  // Digit select; a zero divisor naturally yields all-ones quotient and P = dividend.
  always_comb begin
    d1_c    = PW'(d_q);
    d2_c    = d1_c << 1;
    d3_c    = d2_c + d1_c;
    digit_c = 2'd0;
    p_rem_c = p_sh_c;
    if (p_sh_c >= d3_c) begin
      digit_c = 2'd3;
      p_rem_c = p_sh_c - d3_c;
    end else if (p_sh_c >= d2_c) begin
      digit_c = 2'd2;
      p_rem_c = p_sh_c - d2_c;
    end else if (p_sh_c >= d1_c) begin
      digit_c = 2'd1;
      p_rem_c = p_sh_c - d1_c;
    end
    q_next_c = {q_q[WIDTH-3:0], digit_c};
  end

  // Next-state and output logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    p_d        = p_q;
    q_d        = q_q;
    d_d        = d_q;
    dbz_pend_d = dbz_pend_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    quo_d      = quo_q;
    rem_d      = rem_q;
    dbz_d      = dbz_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = RUN;
          cnt_d      = '0;
          p_d        = '0;
          q_d        = dividend;
          d_d        = divisor;
          dbz_pend_d = (divisor == '0);
          busy_d     = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        p_d   = p_rem_c;
        q_d   = q_next_c;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(ITER_N - 1)) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          quo_d   = q_next_c;
          rem_d   = p_rem_c[WIDTH-1:0];
          dbz_d   = dbz_pend_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      p_q        <= '0;
      q_q        <= '0;
      d_q        <= '0;
      dbz_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      quo_q      <= '0;
      rem_q      <= '0;
      dbz_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      p_q        <= p_d;
      q_q        <= q_d;
      d_q        <= d_d;
      dbz_pend_q <= dbz_pend_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      quo_q      <= quo_d;
      rem_q      <= rem_d;
      dbz_q      <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_radix4_div.sv
// Scoreboard bench for radix4_div (WIDTH=8): results and done latency checked on each done.
module tb_radix4_div;

  localparam int unsigned W   = 8;
  localparam int          LAT = 5;  // drive negedge -> done-visible negedge, in cycle counts

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  radix4_div #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int c);
    exp_t e;
    if (b == '0) begin
      e.q   = '1;
      e.r   = a;
      e.dbz = 1'b1;
    end else begin
      e.q   = a / b;
      e.r   = a % b;
      e.dbz = 1'b0;
    end
    e.cyc = c;
    return e;
  endfunction

  // Scoreboard monitor: every done must match the oldest pending op.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 32'(done), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("quotient", 32'(quotient), 32'(mon_e.q));
        chk("remainder", 32'(remainder), 32'(mon_e.r));
        chk("div_by_zero", 32'(div_by_zero), 32'(mon_e.dbz));
        chk("latency", 32'(cyc), 32'(mon_e.cyc));
        chk("busy_at_done", 32'(busy), 32'd0);
      end
    end
  end

  // Called just after a negedge; returns just after the accepting edge's negedge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    if (push) sb.push_back(model(a, b, cyc + LAT));
    @(negedge clk);
    start = 1'b0;
  endtask

  // Returns at the negedge where done is visible (or flags a timeout).
  task automatic wait_done();
    int n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!done) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
    start_op(a, b, 1'b1);
    chk("busy_running", 32'(busy), 32'd1);
    wait_done();
    @(negedge clk);
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_quotient", 32'(quotient), 32'd0);
    chk("rst_remainder", 32'(remainder), 32'd0);
    chk("rst_dbz", 32'(div_by_zero), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed operands including boundary cases and divide by zero.
    run_op(8'd200, 8'd7);
    run_op(8'd255, 8'd1);
    run_op(8'd5,   8'd9);
    run_op(8'd0,   8'd3);
    run_op(8'd255, 8'd255);
    run_op(8'd77,  8'd0);
    chk("dbz_held", 32'(div_by_zero), 32'd1);
    chk("dbz_rem_held", 32'(remainder), 32'd77);

    // Start pulsed mid-run must be ignored.
    start_op(8'd200, 8'd7, 1'b1);
    @(negedge clk);
    dividend = 8'd9;
    divisor  = 8'd2;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    @(negedge clk);
    repeat (5) @(negedge clk);
    chk("ignored_start_idle", 32'(busy), 32'd0);

    // Reset two cycles into a run aborts it with no done.
    start_op(8'd50, 8'd3, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_quotient", 32'(quotient), 32'd0);
    chk("abort_remainder", 32'(remainder), 32'd0);
    chk("abort_dbz", 32'(div_by_zero), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("abort_no_done", 32'(done), 32'd0);
    run_op(8'd17, 8'd5);

    // Back-to-back: second start in the DONE cycle; first results held meanwhile.
    start_op(8'd100, 8'd3, 1'b1);
    wait_done();
    start_op(8'd250, 8'd16, 1'b1);
    chk("b2b_busy", 32'(busy), 32'd1);
    chk("b2b_held_q", 32'(quotient), 32'd33);
    chk("b2b_held_r", 32'(remainder), 32'd1);
    @(negedge clk);
    @(negedge clk);
    chk("b2b_held_q2", 32'(quotient), 32'd33);
    wait_done();
    @(negedge clk);

    // Random pairs, mixing idle gaps with back-to-back starts.
    for (int i = 0; i < 1500; i++) begin
      logic [W-1:0] a, b;
      a = W'($urandom_range(0, 255));
      case (i % 8)
        0:       b = '0;
        1:       b = W'($urandom_range(1, 3));
        2:       b = '1;
        default: b = W'($urandom_range(0, 255));
      endcase
      start_op(a, b, 1'b1);
      wait_done();
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
    @(negedge clk);

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
